// File: rtl/tile_field_renderer_if.sv
// Memory-side bus of the tile field renderer: cell-state memory read port and tile ROM read port.
interface tile_field_renderer_if #(
    parameter int CELL_AW = 9,
    parameter int TILE_AW = 14
);
    logic [CELL_AW-1:0] cell_addr;
    logic [3:0]         cell_code;
    logic [TILE_AW-1:0] tile_addr;
    logic [11:0]        tile_pixel;

    modport master (output cell_addr, output tile_addr, input cell_code, input tile_pixel);
    modport slave  (input cell_addr, input tile_addr, output cell_code, output tile_pixel);
endinterface

// File: rtl/tile_field_renderer.sv
// Three-stage pixel pipeline mapping a raster coordinate onto a tiled game field, with cursor
// overlay, invalid-code highlighting and frame-rate action/blink timing.
module tile_field_renderer #(
    parameter int          H_ACTIVE        = 800,
    parameter int          V_ACTIVE        = 600,
    parameter int          TILE_LOG2       = 5,
    parameter int          FIELD_W         = 25,
    parameter int          FIELD_H         = 16,
    parameter int          FIELD_X0        = 0,
    parameter int          FIELD_Y0        = 44,
    parameter int          TILE_KINDS      = 13,
    parameter int          FRAMES_PER_TICK = 3,
    parameter int          BLINK_FRAMES    = 16,
    parameter logic [11:0] CURSOR_RGB      = 12'hFF0,
    parameter logic [11:0] ERROR_RGB       = 12'hF0F
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                h_coord,
    input  logic [9:0]                 v_coord,
    tile_field_renderer_if.master      mem,
    input  logic [$clog2(FIELD_W)-1:0] cursor_x,
    input  logic [$clog2(FIELD_H)-1:0] cursor_y,
    input  logic                       cursor_en,
    input  logic [11:0]                bg_rgb,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue,
    output logic                       end_of_frame,
    output logic                       action_tick
);
    localparam int TILE     = 1 << TILE_LOG2;
    localparam int CELL_AW  = $clog2(FIELD_W * FIELD_H);
    localparam int CX_W     = $clog2(FIELD_W);
    localparam int CY_W     = $clog2(FIELD_H);
    localparam int FC_W     = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam int BC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int FIELD_X1 = FIELD_X0 + FIELD_W * TILE;
    localparam int FIELD_Y1 = FIELD_Y0 + FIELD_H * TILE;
    localparam logic [TILE_LOG2-1:0] EDGE_LO = TILE_LOG2'(1);
    localparam logic [TILE_LOG2-1:0] EDGE_HI = TILE_LOG2'(TILE - 2);

    logic [31:0]          h_ext_s, v_ext_s, h_off_s, v_off_s, col_s, row_s, addr_s;
    logic                 active_s, in_field_s, last_pix_s;
    logic                 unused_addr_s;

    logic                 active1_r, in_field1_r;
    logic [CELL_AW-1:0]   cell_addr_r;
    logic [TILE_LOG2-1:0] px1_r, py1_r;
    logic [CX_W-1:0]      col1_r;
    logic [CY_W-1:0]      row1_r;

    logic                 border_s, bad_s;
    logic                 active2_r, in_field2_r, cur2_r, bad2_r;
    logic [3+2*TILE_LOG2:0] tile_addr_r;

    logic [11:0]          color_s, rgb_r;
    logic                 end_of_frame_r, action_tick_r, blink_on_r;
    logic                 frame_wrap_s, blink_wrap_s;
    logic [FC_W-1:0]      frame_cnt_r;
    logic [BC_W-1:0]      blink_cnt_r;

    // Coordinate decode; the range test is done before subtraction so pixels left of or above
    // the origin never wrap into the field.
    always_comb begin
        h_ext_s    = {21'd0, h_coord};
        v_ext_s    = {22'd0, v_coord};
        h_off_s    = h_ext_s - 32'(FIELD_X0);
        v_off_s    = v_ext_s - 32'(FIELD_Y0);
        active_s   = (h_ext_s < 32'(H_ACTIVE)) && (v_ext_s < 32'(V_ACTIVE));
        in_field_s = active_s
                     && (h_ext_s >= 32'(FIELD_X0)) && (h_ext_s < 32'(FIELD_X1))
                     && (v_ext_s >= 32'(FIELD_Y0)) && (v_ext_s < 32'(FIELD_Y1));
        col_s      = h_off_s >> TILE_LOG2;
        row_s      = v_off_s >> TILE_LOG2;
        if (in_field_s) begin
            addr_s = row_s * 32'(FIELD_W) + col_s;
        end else begin
            addr_s = 32'd0;
        end
        last_pix_s = (h_ext_s == 32'(H_ACTIVE - 1)) && (v_ext_s == 32'(V_ACTIVE - 1));
    end

    assign unused_addr_s = ^addr_s[31:CELL_AW];

    // Stage 0: register the decoded coordinate and issue the cell memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            active1_r   <= 1'b0;
            in_field1_r <= 1'b0;
            cell_addr_r <= {CELL_AW{1'b0}};
            px1_r       <= {TILE_LOG2{1'b0}};
            py1_r       <= {TILE_LOG2{1'b0}};
            col1_r      <= {CX_W{1'b0}};
            row1_r      <= {CY_W{1'b0}};
        end else begin
            active1_r   <= active_s;
            in_field1_r <= in_field_s;
            cell_addr_r <= addr_s[CELL_AW-1:0];
            px1_r       <= h_off_s[TILE_LOG2-1:0];
            py1_r       <= v_off_s[TILE_LOG2-1:0];
            col1_r      <= col_s[CX_W-1:0];
            row1_r      <= row_s[CY_W-1:0];
        end
    end

    // The cursor frame is two pixels thick on every side of the tile.
    always_comb begin
        border_s = (px1_r <= EDGE_LO) || (px1_r >= EDGE_HI)
                   || (py1_r <= EDGE_LO) || (py1_r >= EDGE_HI);
        bad_s    = ({1'b0, mem.cell_code} >= 5'(TILE_KINDS));
    end

    // Stage 1: cell code is back; form the tile ROM address and the overlay flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_addr_r <= {(4 + 2 * TILE_LOG2){1'b0}};
            active2_r   <= 1'b0;
            in_field2_r <= 1'b0;
            bad2_r      <= 1'b0;
            cur2_r      <= 1'b0;
        end else begin
            tile_addr_r <= {mem.cell_code, py1_r, px1_r};
            active2_r   <= active1_r;
            in_field2_r <= in_field1_r;
            bad2_r      <= bad_s;
            cur2_r      <= cursor_en && blink_on_r && (col1_r == cursor_x)
                           && (row1_r == cursor_y) && border_s;
        end
    end

    // Colour priority: blanking, background, cursor, invalid code, tile bitmap.
    always_comb begin
        if (!active2_r) begin
            color_s = 12'h000;
        end else if (!in_field2_r) begin
            color_s = bg_rgb;
        end else if (cur2_r) begin
            color_s = CURSOR_RGB;
        end else if (bad2_r) begin
            color_s = ERROR_RGB;
        end else begin
            color_s = mem.tile_pixel;
        end
    end

    // Stage 2: output colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= color_s;
        end
    end

    always_comb begin
        frame_wrap_s = (frame_cnt_r == FC_W'(FRAMES_PER_TICK - 1));
        blink_wrap_s = (blink_cnt_r == BC_W'(BLINK_FRAMES - 1));
    end

    // Frame strobes and blink phase; everything advances on the last active pixel, so blink
    // state only changes between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            end_of_frame_r <= 1'b0;
            action_tick_r  <= 1'b0;
            frame_cnt_r    <= {FC_W{1'b0}};
            blink_cnt_r    <= {BC_W{1'b0}};
            blink_on_r     <= 1'b1;
        end else begin
            end_of_frame_r <= last_pix_s;
            action_tick_r  <= last_pix_s && frame_wrap_s;
            if (last_pix_s) begin
                if (frame_wrap_s) begin
                    frame_cnt_r <= {FC_W{1'b0}};
                end else begin
                    frame_cnt_r <= frame_cnt_r + FC_W'(1);
                end
                if (blink_wrap_s) begin
                    blink_cnt_r <= {BC_W{1'b0}};
                    blink_on_r  <= !blink_on_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BC_W'(1);
                end
            end
        end
    end

    assign mem.cell_addr = cell_addr_r;
    assign mem.tile_addr = tile_addr_r;
    assign red           = rgb_r[3:0];
    assign green         = rgb_r[7:4];
    assign blue          = rgb_r[11:8];
    assign end_of_frame  = end_of_frame_r;
    assign action_tick   = action_tick_r;

endmodule

// File: tb/tb_tile_field_renderer.sv
// Randomised self-checking bench for tile_field_renderer against a coordinate-level reference model.
module tb_tile_field_renderer;
    localparam int W = 25, H = 16, TS = 32, X0 = 0, Y0 = 44, NP = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_coord = 11'd0;
    logic [9:0]  v_coord = 10'd0;
    logic [4:0]  cursor_x = 5'd0;
    logic [3:0]  cursor_y = 4'd0;
    logic        cursor_en = 1'b0;
    logic [11:0] bg_rgb = 12'h123;
    logic [3:0]  red, green, blue;
    logic        end_of_frame, action_tick;
    logic [3:0]  cell_mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;
    int np       = 0;
    int frames   = 0;

    logic [11:0] exp_rgb [0:NP-1];
    logic [11:0] obs_rgb [0:NP-1];
    logic [8:0]  exp_ca  [0:NP-1];
    logic [8:0]  obs_ca  [0:NP-1];
    logic [13:0] exp_ta  [0:NP-1];
    logic [13:0] obs_ta  [0:NP-1];
    bit          ta_chk  [0:NP-1];
    logic        exp_eof [0:NP-1];
    logic        obs_eof [0:NP-1];
    logic        exp_tick[0:NP-1];
    logic        obs_tick[0:NP-1];

    tile_field_renderer_if #(.CELL_AW(9), .TILE_AW(14)) mif ();

    tile_field_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .h_coord(h_coord), .v_coord(v_coord), .mem(mif),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en), .bg_rgb(bg_rgb),
        .red(red), .green(green), .blue(blue),
        .end_of_frame(end_of_frame), .action_tick(action_tick)
    );

    function automatic logic [11:0] rom_word(input logic [3:0] c, input logic [4:0] py, input logic [4:0] px);
        return {c ^ py[4:1], px[3:0] + py[3:0], ~c ^ px[4:1]};
    endfunction

    assign mif.cell_code  = cell_mem[mif.cell_addr];
    assign mif.tile_pixel = rom_word(mif.tile_addr[13:10], mif.tile_addr[9:5], mif.tile_addr[4:0]);

    always #5 clk = ~clk;

    function automatic bit in_field_f(input int h, input int v);
        return (h < 800) && (v < 600) && (h >= X0) && (h < X0 + W * TS) && (v >= Y0) && (v < Y0 + H * TS);
    endfunction

    function automatic logic [11:0] model_rgb(input int h, input int v, input bit blink);
        int col, row, px, py;
        bit border;
        logic [3:0] code;
        if (h >= 800 || v >= 600) return 12'h000;
        if (!in_field_f(h, v)) return bg_rgb;
        col = (h - X0) / TS;  row = (v - Y0) / TS;
        px  = (h - X0) % TS;  py  = (v - Y0) % TS;
        code = cell_mem[row * W + col];
        border = (px < 2) || (px >= TS - 2) || (py < 2) || (py >= TS - 2);
        if (cursor_en && blink && col == int'(cursor_x) && row == int'(cursor_y) && border) return 12'hFF0;
        if (code >= 4'd13) return 12'hF0F;
        return rom_word(code, 5'(py), 5'(px));
    endfunction

    // Drive one pixel, record the model's expectation and capture what the DUT shows.
    task automatic step(input int hh, input int vv, input bit do_rst);
        int col, row;
        bit last, blink;
        @(negedge clk);
        h_coord = 11'(hh);
        v_coord = 10'(vv);
        rst     = do_rst;
        last    = (hh == 799) && (vv == 599);
        if (do_rst) begin
            frames = 0;
            exp_rgb[np] = 12'h000; exp_eof[np] = 1'b0; exp_tick[np] = 1'b0;
            exp_ca[np]  = 9'd0;    ta_chk[np]  = 1'b0;
            if (np >= 1) begin exp_rgb[np-1] = 12'h000; exp_ta[np-1] = 14'd0; ta_chk[np-1] = 1'b1; end
            if (np >= 2) exp_rgb[np-2] = 12'h000;
        end else begin
            if (last) frames++;
            blink        = ((frames / 2) % 2) == 0;
            exp_eof[np]  = last;
            exp_tick[np] = last && (frames % 3 == 0);
            exp_rgb[np]  = model_rgb(hh, vv, blink);
            if (in_field_f(hh, vv)) begin
                col = (hh - X0) / TS; row = (vv - Y0) / TS;
                exp_ca[np] = 9'(row * W + col);
                exp_ta[np] = {cell_mem[row * W + col], 5'((vv - Y0) % TS), 5'((hh - X0) % TS)};
                ta_chk[np] = 1'b1;
            end else begin
                exp_ca[np] = 9'd0;
                ta_chk[np] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        obs_eof[np]  = end_of_frame;
        obs_tick[np] = action_tick;
        obs_ca[np]   = mif.cell_addr;
        if (np >= 1) obs_ta[np-1]  = mif.tile_addr;
        if (np >= 2) obs_rgb[np-2] = {blue, green, red};
        np++;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1000, 700, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(37, 114, 1'b1);
            n_checks++;
            if ({blue, green, red, end_of_frame, action_tick} !== 14'd0 || mif.cell_addr !== 9'd0 || mif.tile_addr !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_state rgb=%h eof=%b tick=%b ca=%0d ta=%h required all zero", {blue, green, red}, end_of_frame, action_tick, mif.cell_addr, mif.tile_addr);
            end
        end
        flush(3);
    endtask

    task automatic test_field_mapping();
        int p0 = np;
        step(37, 114, 1'b0);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 799), $urandom_range(44, 555), 1'b0);
        flush(3);
        n_checks++;
        if (obs_ca[p0] !== 9'd51) begin n_fail++; $display("FAIL map_cell_addr got %0d want 51", obs_ca[p0]); end
        n_checks++;
        if (obs_ta[p0] !== {4'd12, 5'd6, 5'd5}) begin n_fail++; $display("FAIL map_tile_addr got %h want %h", obs_ta[p0], {4'd12, 5'd6, 5'd5}); end
        n_checks++;
        if (obs_rgb[p0] !== rom_word(4'd12, 5'd6, 5'd5)) begin n_fail++; $display("FAIL map_rgb got %h want %h", obs_rgb[p0], rom_word(4'd12, 5'd6, 5'd5)); end
        for (int p = p0; p < np - 2; p++) begin
            n_checks++;
            if (obs_rgb[p] !== exp_rgb[p] || obs_ca[p] !== exp_ca[p] || (ta_chk[p] && obs_ta[p] !== exp_ta[p])) begin
                n_fail++;
                $display("FAIL map_random p=%0d rgb %h/%h ca %0d/%0d ta %h/%h (got/want)", p, obs_rgb[p], exp_rgb[p], obs_ca[p], exp_ca[p], obs_ta[p], exp_ta[p]);
            end
        end
    endtask

    task automatic test_region_priority();
        int p0;
        bg_rgb = 12'($urandom);
        flush(3);
        p0 = np;
        for (int i = 0; i < 1100; i++) step(i, 10, 1'b0);
        for (int i = 0; i < 1100; i++) step(i, 600, 1'b0);
        flush(3);
        for (int i = 0; i < 2200; i++) begin
            n_checks++;
            if (obs_rgb[p0+i] !== (((i < 800)) ? bg_rgb : 12'h000)) begin
                n_fail++;
                $display("FAIL region i=%0d got %h want %h", i, obs_rgb[p0+i], (i < 800) ? bg_rgb : 12'h000);
            end
        end
    endtask

    task automatic test_invalid_code();
        int p0;
        logic [11:0] want;
        step(1000, 700, 1'b1);
        cell_mem[180] = 4'd14;
        cursor_en = 1'b0;
        flush(3);
        for (int pass = 0; pass < 2; pass++) begin
            p0 = np;
            for (int py = 0; py < 32; py++)
                for (int px = 0; px < 32; px++) step(5 * 32 + px, 44 + 7 * 32 + py, 1'b0);
            flush(3);
            for (int i = 0; i < 1024; i++) begin
                want = (pass == 1 && ((i % 32) < 2 || (i % 32) > 29 || (i / 32) < 2 || (i / 32) > 29)) ? 12'hFF0 : 12'hF0F;
                n_checks++;
                if (obs_rgb[p0+i] !== want) begin
                    n_fail++;
                    $display("FAIL invalid_code pass=%0d px=%0d py=%0d got %h want %h", pass, i % 32, i / 32, obs_rgb[p0+i], want);
                end
            end
            cursor_x = 5'd5; cursor_y = 4'd7; cursor_en = 1'b1;
            flush(1);
        end
        cell_mem[180] = 4'(180 % 13);
        cursor_en = 1'b0;
        flush(3);
    endtask

    task automatic test_cursor_blink();
        int pix_p[$], pix_f[$], pix_x[$], pix_y[$];
        int xs[6] = '{0, 1, 30, 31, 15, 15};
        int ys[6] = '{10, 10, 10, 10, 15, 0};
        logic [11:0] want;
        bit border;
        step(1000, 700, 1'b1);
        cursor_x = 5'd3; cursor_y = 4'd2; cursor_en = 1'b1;
        flush(3);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 6; k++) begin
                pix_p.push_back(np); pix_f.push_back(f); pix_x.push_back(xs[k]); pix_y.push_back(ys[k]);
                step(3 * 32 + xs[k], 44 + 2 * 32 + ys[k], 1'b0);
            end
            step(799, 599, 1'b0);
            step(1000, 700, 1'b0);
        end
        flush(3);
        for (int i = 0; i < pix_p.size(); i++) begin
            border = (pix_x[i] < 2 || pix_x[i] > 29 || pix_y[i] < 2 || pix_y[i] > 29);
            want = (border && ((pix_f[i] / 2) % 2 == 0)) ? 12'hFF0 : rom_word(4'd1, 5'(pix_y[i]), 5'(pix_x[i]));
            n_checks++;
            if (obs_rgb[pix_p[i]] !== want) begin
                n_fail++;
                $display("FAIL cursor_blink frame=%0d px=%0d py=%0d got %h want %h", pix_f[i], pix_x[i], pix_y[i], obs_rgb[pix_p[i]], want);
            end
        end
        cursor_en = 1'b0;
        flush(3);
    endtask

    task automatic test_ticks();
        int p0, n_eof, ticks[$];
        step(1000, 700, 1'b1);
        p0 = np;
        for (int f = 0; f < 7; f++) begin
            step($urandom_range(0, 1100), $urandom_range(0, 598), 1'b0);
            step(799, 599, 1'b0);
            step(1000, 700, 1'b0);
        end
        flush(3);
        n_eof = 0;
        for (int p = p0; p < np; p++) begin
            if (obs_eof[p] === 1'b1) begin
                n_eof++;
                if (obs_tick[p] === 1'b1) ticks.push_back(n_eof);
            end
            n_checks++;
            if (obs_eof[p] !== exp_eof[p] || obs_tick[p] !== exp_tick[p]) begin
                n_fail++;
                $display("FAIL ticks p=%0d eof %b/%b tick %b/%b (got/want)", p, obs_eof[p], exp_eof[p], obs_tick[p], exp_tick[p]);
            end
        end
        n_checks++;
        if (n_eof != 7 || ticks.size() != 2 || ticks[0] != 3 || ticks[1] != 6) begin
            n_fail++;
            $display("FAIL tick_pattern eof_count=%0d tick_count=%0d want eof_count=7 ticks at pulses 3 and 6", n_eof, ticks.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int pr, p0, n_eof, ticks[$];
        step(1000, 700, 1'b1);
        step(799, 599, 1'b0);
        step(799, 599, 1'b0);
        for (int i = 0; i < 4; i++) step(396 + i, 300, 1'b0);
        pr = np;
        step(400, 300, 1'b1);
        step(401, 300, 1'b0);
        step(402, 300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs_rgb[pr-2+i] !== 12'h000) begin n_fail++; $display("FAIL reset_mid_rgb cycle=%0d got %h want 000", i + 1, obs_rgb[pr-2+i]); end
        end
        p0 = np;
        for (int f = 0; f < 3; f++) begin
            step(799, 599, 1'b0);
            step($urandom_range(0, 799), $urandom_range(44, 555), 1'b0);
        end
        flush(3);
        n_eof = 0;
        for (int p = p0; p < np; p++) begin
            if (obs_eof[p] === 1'b1) begin
                n_eof++;
                if (obs_tick[p] === 1'b1) ticks.push_back(n_eof);
            end
        end
        n_checks++;
        if (n_eof != 3 || ticks.size() != 1 || ticks[0] != 3) begin
            n_fail++;
            $display("FAIL reset_mid_tick eof_count=%0d tick_count=%0d want 3 pulses with a tick on the third only", n_eof, ticks.size());
        end
        for (int p = pr - 2; p < np - 2; p++) begin
            n_checks++;
            if (obs_rgb[p] !== exp_rgb[p]) begin n_fail++; $display("FAIL reset_mid_stream p=%0d got %h want %h", p, obs_rgb[p], exp_rgb[p]); end
        end
    endtask

    task automatic test_back_to_back();
        int p0, cx, cy;
        step(1000, 700, 1'b1);
        p0 = np;
        for (int c = 0; c < 5; c++) begin
            for (int a = 0; a < 512; a++) cell_mem[a] = 4'($urandom_range(0, 15));
            cx = $urandom_range(0, 24); cy = $urandom_range(0, 15);
            cursor_x = 5'(cx); cursor_y = 4'(cy); cursor_en = 1'($urandom_range(0, 3) != 0);
            bg_rgb = 12'($urandom);
            flush(3);
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 39) == 0) step(799, 599, 1'b0);
                else if ($urandom_range(0, 1) == 0) step(X0 + cx * TS + $urandom_range(0, 31), Y0 + cy * TS + $urandom_range(0, 31), 1'b0);
                else step($urandom_range(0, 1100), $urandom_range(0, 700), 1'b0);
            end
            flush(3);
        end
        for (int p = p0; p < np - 2; p++) begin
            n_checks++;
            if (obs_rgb[p] !== exp_rgb[p] || obs_ca[p] !== exp_ca[p] || (ta_chk[p] && obs_ta[p] !== exp_ta[p])
                || obs_eof[p] !== exp_eof[p] || obs_tick[p] !== exp_tick[p]) begin
                n_fail++;
                $display("FAIL back_to_back p=%0d rgb %h/%h ca %0d/%0d ta %h/%h eof %b/%b tick %b/%b (got/want)", p,
                         obs_rgb[p], exp_rgb[p], obs_ca[p], exp_ca[p], obs_ta[p], exp_ta[p], obs_eof[p], exp_eof[p], obs_tick[p], exp_tick[p]);
            end
        end
        cursor_en = 1'b0;
        for (int a = 0; a < 512; a++) cell_mem[a] = 4'(a % 13);
        flush(3);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) cell_mem[a] = 4'(a % 13);
        test_reset();
        test_field_mapping();
        test_region_priority();
        test_invalid_code();
        test_cursor_blink();
        test_ticks();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
